// File: rtl/mvm_noc_top.sv
// MVM tile NoC endpoint: single-flit AXI-Stream in, RF bank writes,
// int8 dot-product compute, single-flit AXI-Stream result out.
// Optional build macro: MVM_RELU_EN clamps negative dot products to 0.

// One int8 x int8 signed multiplier lane.
module mvm_lane (
  input  logic signed [7:0]  w,
  input  logic signed [7:0]  v,
  output logic signed [15:0] p
);
  assign p = w * v;
endmodule

module mvm_noc_top #(
  parameter int          DATAW    = 512,
  parameter int          IDW      = 32,
  parameter int          DESTW    = 12,
  parameter int          USERW    = 76,
  parameter int          NUM_RF   = 64,
  parameter int          RF_DEPTH = 16,
  parameter logic [11:0] NODE_ID  = 12'h002,
  parameter logic [11:0] RES_DEST = 12'h000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             AXIS_S_TVALID,
  output logic             AXIS_S_TREADY,
  input  logic [DATAW-1:0] AXIS_S_TDATA,
  input  logic             AXIS_S_TLAST,
  input  logic [IDW-1:0]   AXIS_S_TID,
  input  logic [USERW-1:0] AXIS_S_TUSER,
  input  logic [DESTW-1:0] AXIS_S_TDEST,
  output logic             AXIS_M_TVALID,
  input  logic             AXIS_M_TREADY,
  output logic [DATAW-1:0] AXIS_M_TDATA,
  output logic             AXIS_M_TLAST,
  output logic [IDW-1:0]   AXIS_M_TID,
  output logic [USERW-1:0] AXIS_M_TUSER,
  output logic [DESTW-1:0] AXIS_M_TDEST
);
  localparam int LANES  = DATAW / 8;
  localparam int AW     = $clog2(RF_DEPTH);
  localparam int KW     = $clog2(NUM_RF);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [KW-1:0]    k;
    logic [AW-1:0]    addr;
    logic [DATAW-1:0] vec;
    logic [IDW-1:0]   tid;
    logic [USERW-1:0] tuser;
  } cmp_req_t;

  // Inbound decode
  logic              s_tready, s_hs, for_me, wr_en, cmp_en, busy;
  logic [1:0]        op;
  logic [NUM_RF-1:0] sel;
  logic [AW-1:0]     addr;
  logic [KW-1:0]     low_k;
  logic [STAGES:1]   vld_pipe;

  // Accepts stall while a compute is in flight or a result waits for the router
  assign busy     = |vld_pipe;
  assign s_tready = !RST && !busy && !AXIS_M_TVALID;
  assign s_hs     = AXIS_S_TVALID && s_tready;
  assign for_me   = (AXIS_S_TDEST == DESTW'(NODE_ID));
  assign op       = AXIS_S_TUSER[10:9];
  assign sel      = AXIS_S_TUSER[11 +: NUM_RF];
  assign addr     = AXIS_S_TUSER[AW-1:0];
  assign wr_en    = s_hs && for_me && (op == 2'b11);
  assign cmp_en   = s_hs && for_me && (op == 2'b10);
  assign AXIS_S_TREADY = s_tready;

  // TLAST, the unused address bits and TUSER bits past the select mask carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{AXIS_S_TLAST, AXIS_S_TUSER[USERW-1:11+NUM_RF], AXIS_S_TUSER[8:AW]};

  // Lowest set select bit picks the RF for compute; empty mask falls back to RF 0
  always_comb begin
    low_k = '0;
    for (int i = NUM_RF - 1; i >= 0; i--)
      if (sel[i]) low_k = KW'(i);
  end

  // RF bank: multi-hot broadcast write, contents deliberately not reset
  logic [DATAW-1:0] rf_mem [NUM_RF][RF_DEPTH];
  always_ff @(posedge CLK) begin
    if (wr_en)
      for (int k = 0; k < NUM_RF; k++)
        if (sel[k]) rf_mem[k][addr] <= AXIS_S_TDATA;
  end

  // Compute pipeline valid bits; reset drops anything in flight
  always_ff @(posedge CLK) begin
    if (RST) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:1], cmp_en};
  end

  // Stage 1 captures the request, stage 2 holds the registered RF read
  cmp_req_t         s1, s2;
  logic [DATAW-1:0] rd_q;
  always_ff @(posedge CLK) begin
    if (cmp_en) begin
      s1.k     <= low_k;
      s1.addr  <= addr;
      s1.vec   <= AXIS_S_TDATA;
      s1.tid   <= AXIS_S_TID;
      s1.tuser <= AXIS_S_TUSER;
    end
    if (vld_pipe[1]) begin
      rd_q <= rf_mem[s1.k][s1.addr];
      s2   <= s1;
    end
  end

  // Lane multipliers
  logic [LANES-1:0][15:0] prod;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mvm_lane u_lane (
      .w (rd_q[i*8 +: 8]),
      .v (s2.vec[i*8 +: 8]),
      .p (prod[i])
    );
  end

  // Signed reduction of lane products into the 32-bit accumulator
  logic [31:0] acc, res;
  always_comb begin
    acc = '0;
    for (int i = 0; i < LANES; i++)
      acc = acc + {{16{prod[i][15]}}, prod[i]};
  end

`ifdef MVM_RELU_EN
  assign res = acc[31] ? 32'd0 : acc;
`else
  assign res = acc;
`endif

  // Result flit register: loads at the end of stage 2, holds under backpressure
  always_ff @(posedge CLK) begin
    if (RST) begin
      AXIS_M_TVALID <= 1'b0;
      AXIS_M_TLAST  <= 1'b0;
      AXIS_M_TDATA  <= '0;
      AXIS_M_TID    <= '0;
      AXIS_M_TUSER  <= '0;
      AXIS_M_TDEST  <= '0;
    end else if (vld_pipe[STAGES]) begin
      AXIS_M_TVALID <= 1'b1;
      AXIS_M_TLAST  <= 1'b1;
      AXIS_M_TDATA  <= {{(DATAW-32){res[31]}}, res};
      AXIS_M_TID    <= s2.tid;
      AXIS_M_TUSER  <= s2.tuser;
      AXIS_M_TDEST  <= DESTW'(RES_DEST);
    end else if (AXIS_M_TVALID && AXIS_M_TREADY) begin
      AXIS_M_TVALID <= 1'b0;
      AXIS_M_TLAST  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mvm_noc_top.sv
// Self-checking bench for mvm_noc_top: directed scenarios plus random
// write/compute traffic checked against an array-based RF model.
module tb_mvm_noc_top;
  localparam logic [11:0] NODE = 12'h002;

  logic         clk = 1'b0, rst = 1'b1;
  logic         s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [511:0] s_tdata = '0;
  logic [31:0]  s_tid = '0;
  logic [75:0]  s_tuser = '0;
  logic [11:0]  s_tdest = '0;
  logic         m_tvalid, m_tready = 1'b0, m_tlast;
  logic [511:0] m_tdata;
  logic [31:0]  m_tid;
  logic [75:0]  m_tuser;
  logic [11:0]  m_tdest;

  int errors = 0, checks = 0;

  logic [511:0] model_rf [64][16];
  bit           written  [64][16];

  mvm_noc_top dut (
    .CLK(clk), .RST(rst),
    .AXIS_S_TVALID(s_tvalid), .AXIS_S_TREADY(s_tready), .AXIS_S_TDATA(s_tdata),
    .AXIS_S_TLAST(s_tlast), .AXIS_S_TID(s_tid), .AXIS_S_TUSER(s_tuser), .AXIS_S_TDEST(s_tdest),
    .AXIS_M_TVALID(m_tvalid), .AXIS_M_TREADY(m_tready), .AXIS_M_TDATA(m_tdata),
    .AXIS_M_TLAST(m_tlast), .AXIS_M_TID(m_tid), .AXIS_M_TUSER(m_tuser), .AXIS_M_TDEST(m_tdest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [75:0] mk_user(input logic [63:0] mask, input logic [1:0] op,
                                          input logic [8:0] addr, input logic top);
    mk_user = {top, mask, op, addr};
  endfunction

  // Reference dot product straight from the lane arithmetic definition
  function automatic logic [511:0] dot(input logic [511:0] w, input logic [511:0] v);
    int  s = 0;
    byte a, b;
    logic signed [511:0] e;
    for (int i = 0; i < 64; i++) begin
      a = w[i*8 +: 8];
      b = v[i*8 +: 8];
      s += int'(a) * int'(b);
    end
`ifdef MVM_RELU_EN
    if (s < 0) s = 0;
`endif
    e = s;
    dot = e;
  endfunction

  // Present one flit, wait (bounded) for ready, return 1ns after the accept edge
  task automatic send(input logic [511:0] d, input logic [75:0] u, input logic [11:0] dst,
                      input logic [31:0] id, input bit chk_rdy);
    int n = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tuser = u; s_tdest = dst; s_tid = id;
    s_tlast = 1'($urandom_range(0, 1));
    if (chk_rdy) chk("s_tready_b2b", 512'(s_tready), 512'd1);
    while (!s_tready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("s_tready_timeout", 512'(s_tready), 512'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] mask, input logic [8:0] addr, input logic [511:0] d,
                          input logic [11:0] dst, input logic [1:0] op, input bit chk_rdy);
    send(d, mk_user(mask, op, addr, 1'($urandom_range(0, 1))), dst, $urandom, chk_rdy);
    if (dst == NODE && op == 2'b11)
      for (int k = 0; k < 64; k++)
        if (mask[k]) begin
          model_rf[k][addr[3:0]] = d;
          written[k][addr[3:0]]  = 1'b1;
        end
  endtask

  // Compute, check latency and result fields, optionally stall, then handshake
  task automatic do_compute(input logic [63:0] mask, input logic [8:0] addr, input logic [511:0] v,
                            input int hold, output logic [511:0] got);
    int k = 0, n = 0;
    logic [75:0]  u = mk_user(mask, 2'b10, addr, 1'($urandom_range(0, 1)));
    logic [31:0]  id = $urandom;
    logic [511:0] exp, snap;
    for (int i = 63; i >= 0; i--) if (mask[i]) k = i;
    exp = dot(model_rf[k][addr[3:0]], v);
    send(v, u, NODE, id, 1'b0);
    chk("busy_no_ready", 512'(s_tready), 512'd0);
    while (!m_tvalid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 512'(n), 512'd2);
    chk("m_tdata", m_tdata, exp);
    chk("m_tid", 512'(m_tid), 512'(id));
    chk("m_tuser", 512'(m_tuser), 512'(u));
    chk("m_tdest", 512'(m_tdest), 512'h000);
    chk("m_tlast", 512'(m_tlast), 512'd1);
    got  = m_tdata;
    snap = m_tdata;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", 512'(m_tvalid), 512'd1);
      chk("hold_data", m_tdata, snap);
      chk("hold_no_ready", 512'(s_tready), 512'd0);
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
    chk("valid_cleared", 512'(m_tvalid), 512'd0);
    chk("ready_after_hs", 512'(s_tready), 512'd1);
  endtask

  initial begin
    logic [511:0]        got, d;
    logic signed [511:0] neg64;
    logic [63:0]         mask;
    int                  k, a;

    // Reset
    repeat (4) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 512'(m_tvalid), 512'd0);
    chk("rst_s_tready", 512'(s_tready), 512'd0);
    chk("rst_m_tdata", m_tdata, 512'd0);
    chk("rst_m_tlast", 512'(m_tlast), 512'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 512'(s_tready), 512'd1);

    // Write then compute: 64 * 1 * 2 = 128
    do_write(64'd1, 9'd1, {64{8'h01}}, NODE, 2'b11, 1'b0);
    do_compute(64'd1, 9'd1, {64{8'h02}}, 0, got);
    chk("basic_128", got, 512'd128);

    // Empty mask computes on RF 0
    do_compute(64'd0, 9'd1, {64{8'h03}}, 0, got);
    chk("empty_mask_192", got, 512'd192);

    // Multi-hot write to every RF, compute on RF 63 only
    do_write({64{1'b1}}, 9'd2, {64{8'hFF}}, NODE, 2'b11, 1'b0);
    do_compute(64'd1 << 63, 9'd2, {64{8'h01}}, 0, got);
`ifdef MVM_RELU_EN
    neg64 = '0;
`else
    neg64 = -512'sd64;
`endif
    chk("multihot_neg64", got, neg64);

    // Back-to-back one-hot writes, ready must never drop
    for (int i = 0; i < 64; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_write(64'd1 << i, 9'd7, d, NODE, 2'b11, 1'b1);
    end
    for (int i = 0; i < 64; i++)
      do_compute(64'd1 << i, 9'd7, {16{$urandom}}, 0, got);

    // Destination filter: a foreign write leaves the RF alone
    do_write(64'd1 << 5, 9'd3, {64{8'h11}}, NODE, 2'b11, 1'b0);
    do_write(64'd1 << 5, 9'd3, {64{8'h7F}}, 12'h003, 2'b11, 1'b0);
    do_compute(64'd1 << 5, 9'd3, {64{8'h01}}, 0, got);
    chk("dest_filter_old", got, 512'd1088);

    // Dropped opcodes must not write
    do_write(64'd1 << 5, 9'd3, {64{8'h22}}, NODE, 2'b01, 1'b0);
    do_write(64'd1 << 5, 9'd3, {64{8'h33}}, NODE, 2'b00, 1'b0);
    do_compute(64'd1 << 5, 9'd3, {64{8'h01}}, 0, got);
    chk("dropped_op_old", got, 512'd1088);

    // Backpressure on the result
    do_compute(64'd1, 9'd1, {64{8'hFE}}, 5, got);

    // Reset in the middle of a compute
    send({64{8'h01}}, mk_user(64'd1, 2'b10, 9'd1, 1'b0), NODE, 32'h55, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", 512'(m_tvalid), 512'd0);
    chk("midrst_data", m_tdata, 512'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_result", 512'(m_tvalid), 512'd0);
    chk("midrst_ready", 512'(s_tready), 512'd1);

    // Random traffic against the model
    for (int it = 0; it < 40; it++) begin
      mask = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom} & {$urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_write(mask, 9'($urandom_range(0, 511)), d,
               ($urandom_range(0, 3) == 0) ? 12'h003 : NODE,
               ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'b11, 1'b0);
      k = $urandom_range(0, 63);
      a = $urandom_range(0, 15);
      for (int s = 0; s < 1024 && !written[k][a]; s++) begin
        a = (a + 1) % 16;
        if (a == 0) k = (k + 1) % 64;
      end
      mask = (64'd1 << k) | ({$urandom, $urandom} & ~((64'd2 << k) - 64'd1));
      do_compute(mask, {5'($urandom), 4'(a)}, {16{$urandom}}, $urandom_range(0, 2), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
